cluster_readout_scheduler: RTL and testbench
============================================

CLUSTER_READOUT_SCHEDULER -- requirements
Module: cluster_readout_scheduler

Interface
REQ-001 Parameter CNT_LATENCY, default 4: clock4x cycles from vpfs presentation to valid cnt at the cluster counter output.
REQ-002 Parameter MAX_CLUSTERS, default 8: clusters the packer can emit per bunch crossing (BX).
REQ-003 Parameter BX_MAX, default 3563: last BX number before wrap.
REQ-004 Port clock4x, input, 1: sole clock, 4x the BX rate.
REQ-005 Port reset_n, input, 1: the reset is asynchronous and active-low.
REQ-006 Port bx_strobe, input, 1: one-cycle pulse marking the clock4x cycle in which vpfs were presented to the counter.
REQ-007 Port bc0, input, 1: BX-zero marker, sampled only with bx_strobe.
REQ-008 Port cnt, input, 8: cluster count from the counter pipeline.
REQ-009 Port enable, input, 1: when low, no new captures are taken.
REQ-010 Port pack_ready, input, 1: packer accepts a request.
REQ-011 Port ovf_clear, input, 1: synchronous clear of the statistics counters.
REQ-012 Port pack_start, output, 1: request valid.
REQ-013 Port pack_num, output, 4: clusters to pack, 0..MAX_CLUSTERS.
REQ-014 Port pack_bx, output, 12: BX tag of the request.
REQ-015 Port pack_ovf, output, 1: request BX had more than MAX_CLUSTERS clusters.
REQ-016 Port ovf_count, output, 16: saturating count of overflowed BXs.
REQ-017 Port drop_count, output, 16: saturating count of requests overwritten before acceptance.
REQ-018 Port busy, output, 1: high while a request is pending.

Function
REQ-019 BX counter: on bx_strobe with bc0=1, load 0; on bx_strobe with bc0=0, increment, wrapping BX_MAX -> 0.
REQ-020 The BX value at each bx_strobe (post-update) and the strobe travel together through a CNT_LATENCY-deep shift pipeline.
REQ-021 Capture event: delayed strobe high and enable high; cnt is sampled in that same cycle.
REQ-022 On capture: pack_num = min(cnt, MAX_CLUSTERS); pack_ovf = (cnt > MAX_CLUSTERS); pack_bx = delayed BX tag.
REQ-023 FSM states: IDLE and PEND.
REQ-024 IDLE: capture with cnt > 0 goes to PEND; capture with cnt = 0 stays in IDLE and issues no request.
REQ-025 PEND: pack_start = 1, busy = 1; pack_num, pack_bx and pack_ovf are held stable.
REQ-026 Transfer occurs in the cycle where pack_start and pack_ready are both high; the next cycle returns to IDLE unless a capture coincides.
REQ-027 Capture in PEND without transfer in the same cycle: the new request overwrites the pending one and drop_count increments; a zero-count capture clears to IDLE and also counts as a drop.
REQ-028 Capture coinciding with transfer: no drop; a nonzero capture remains in PEND with the new payload, a zero capture goes to IDLE.
REQ-029 ovf_count increments once per capture with cnt > MAX_CLUSTERS, regardless of FSM state.
REQ-030 Both statistics counters saturate at 0xFFFF.
REQ-031 ovf_clear zeroes both counters; it has priority over a coincident increment.
REQ-032 enable low while in PEND does not cancel the pending request.
REQ-033 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-034 reset_n low asynchronously sets: FSM IDLE, pack_start 0, pack_num 0, pack_bx 0, pack_ovf 0, busy 0, ovf_count 0, drop_count 0, BX counter 0, and all strobe pipeline stages 0.
REQ-035 Reset mid-request discards the pending request without counting a drop; the first capture after release needs a fresh bx_strobe.

Verification
REQ-036 bx_strobe with bc0=1, cnt=5 after 4 cycles, pack_ready=1 -> pack_start for 1 cycle, pack_num=5, pack_bx=0, pack_ovf=0.
REQ-037 cnt=12 at capture -> pack_num=8, pack_ovf=1, ovf_count increments by 1.
REQ-038 pack_ready=0, two captures 4 cycles apart (cnt=3 then cnt=6) -> pack_num changes to 6, drop_count=1, busy stays high.
REQ-039 640 consecutive strobes without bc0, starting from bx=3560 -> pack_bx sequence wraps 3563 -> 0 -> 1.
REQ-040 ovf_count preset to 0xFFFF by stimulus, then another overflow -> stays 0xFFFF; ovf_clear -> 0.
REQ-041 reset_n asserted while in PEND -> pack_start falls immediately (asynchronously), all outputs take the REQ-034 reset values, drop_count unchanged at 0.

Source files
------------

// File: rtl/cluster_readout_scheduler.sv
// Cluster readout scheduler: tags each bunch crossing with its BX number, delays the
// tag to line up with the cluster counter output, and turns each nonzero count into
// a single-entry packer request with overflow and drop statistics.
module cluster_readout_scheduler #(
    parameter int CNT_LATENCY  = 4,
    parameter int MAX_CLUSTERS = 8,
    parameter int BX_MAX       = 3563
) (
    input  logic        clock4x,
    input  logic        reset_n,
    input  logic        bx_strobe,
    input  logic        bc0,
    input  logic [7:0]  cnt,
    input  logic        enable,
    input  logic        pack_ready,
    input  logic        ovf_clear,
    output logic        pack_start,
    output logic [3:0]  pack_num,
    output logic [11:0] pack_bx,
    output logic        pack_ovf,
    output logic [15:0] ovf_count,
    output logic [15:0] drop_count,
    output logic        busy
);

    localparam logic [11:0] LP_BX_MAX = 12'(BX_MAX);
    localparam logic [7:0]  LP_MAXC8  = 8'(MAX_CLUSTERS);
    localparam logic [3:0]  LP_MAXC4  = 4'(MAX_CLUSTERS);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t                       r_state;
    logic [11:0]                  r_bx;
    logic [CNT_LATENCY-1:0]       r_strb_p;
    logic [CNT_LATENCY-1:0][11:0] r_bx_p;
    logic                         r_pack_start;
    logic [3:0]                   r_pack_num;
    logic [11:0]                  r_pack_bx;
    logic                         r_pack_ovf;
    logic                         r_busy;
    logic [15:0]                  r_ovf_count;
    logic [15:0]                  r_drop_count;

    logic [11:0] w_bx_next;
    logic        w_cap;
    logic        w_xfer;
    logic        w_cnt_nz;
    logic        w_cnt_ovf;
    logic [3:0]  w_num;
    logic        w_drop;

    // Counters stick at full scale instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_bx_next = bc0 ? 12'd0 : ((r_bx == LP_BX_MAX) ? 12'd0 : r_bx + 12'd1);
    assign w_cap     = r_strb_p[CNT_LATENCY-1] & enable;
    assign w_xfer    = r_pack_start & pack_ready;
    assign w_cnt_nz  = |cnt;
    assign w_cnt_ovf = (cnt > LP_MAXC8);
    assign w_num     = w_cnt_ovf ? LP_MAXC4 : cnt[3:0];
    assign w_drop    = w_cap & (r_state == ST_PEND) & ~w_xfer;

    // BX counter and the strobe/tag delay line that aligns the tag with cnt.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_bx     <= '0;
            r_strb_p <= '0;
            r_bx_p   <= '0;
        end else begin
            if (bx_strobe) begin
                r_bx <= w_bx_next;
            end
            r_strb_p[0] <= bx_strobe;
            r_bx_p[0]   <= w_bx_next;
            for (int i = 1; i < CNT_LATENCY; i++) begin
                r_strb_p[i] <= r_strb_p[i-1];
                r_bx_p[i]   <= r_bx_p[i-1];
            end
        end
    end

    // Request FSM: a capture always refreshes the payload; a zero count retires the request.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pack_start <= 1'b0;
            r_busy       <= 1'b0;
            r_pack_num   <= '0;
            r_pack_bx    <= '0;
            r_pack_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cap && w_cnt_nz) begin
                        r_state      <= ST_PEND;
                        r_pack_start <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if ((w_cap && !w_cnt_nz) || (!w_cap && w_xfer)) begin
                        r_state      <= ST_IDLE;
                        r_pack_start <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pack_start <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
            if (w_cap) begin
                r_pack_num <= w_num;
                r_pack_bx  <= r_bx_p[CNT_LATENCY-1];
                r_pack_ovf <= w_cnt_ovf;
            end
        end
    end

    // Overflow and drop statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_count  <= '0;
            r_drop_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_cap && w_cnt_ovf) begin
                r_ovf_count <= sat_inc(r_ovf_count);
            end
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end
        end
    end

    assign pack_start = r_pack_start;
    assign pack_num   = r_pack_num;
    assign pack_bx    = r_pack_bx;
    assign pack_ovf   = r_pack_ovf;
    assign busy       = r_busy;
    assign ovf_count  = r_ovf_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_cluster_readout_scheduler.sv
// Bench for cluster_readout_scheduler: directed scenarios plus random traffic,
// compared every cycle against a due-time/queue model of the scheduler.
module tb_cluster_readout_scheduler;

    localparam int L    = 4;
    localparam int MAXC = 8;
    localparam int BXM  = 3563;

    logic        clk;
    logic        reset_n;
    logic        bx_strobe;
    logic        bc0;
    logic [7:0]  cnt;
    logic        enable;
    logic        pack_ready;
    logic        ovf_clear;
    logic        pack_start;
    logic [3:0]  pack_num;
    logic [11:0] pack_bx;
    logic        pack_ovf;
    logic [15:0] ovf_count;
    logic [15:0] drop_count;
    logic        busy;

    cluster_readout_scheduler #(
        .CNT_LATENCY (L),
        .MAX_CLUSTERS(MAXC),
        .BX_MAX      (BXM)
    ) dut (
        .clock4x   (clk),
        .reset_n   (reset_n),
        .bx_strobe (bx_strobe),
        .bc0       (bc0),
        .cnt       (cnt),
        .enable    (enable),
        .pack_ready(pack_ready),
        .ovf_clear (ovf_clear),
        .pack_start(pack_start),
        .pack_num  (pack_num),
        .pack_bx   (pack_bx),
        .pack_ovf  (pack_ovf),
        .ovf_count (ovf_count),
        .drop_count(drop_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int bx;
    } ent_t;

    ent_t q[$];
    int   cyc     = 0;
    int   bxm     = 0;
    int   m_pend  = 0;
    int   m_num   = 0;
    int   m_bx    = 0;
    int   m_ovf   = 0;
    int   m_ovfc  = 0;
    int   m_dropc = 0;

    task automatic mreset();
        q.delete();
        bxm     = 0;
        m_pend  = 0;
        m_num   = 0;
        m_bx    = 0;
        m_ovf   = 0;
        m_ovfc  = 0;
        m_dropc = 0;
    endtask

    task automatic mstep();
        int c;
        int tag;
        bit cap;
        bit xfer;
        c    = int'(cnt);
        tag  = 0;
        cap  = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            tag = q[0].bx;
            void'(q.pop_front());
            cap = enable;
        end
        xfer = (m_pend != 0) && pack_ready;
        if (cap) begin
            if (c > MAXC && m_ovfc < 65535) m_ovfc++;
            if (m_pend != 0 && !xfer && m_dropc < 65535) m_dropc++;
            if (c != 0) begin
                m_pend = 1;
                m_num  = (c > MAXC) ? MAXC : c;
                m_bx   = tag;
                m_ovf  = (c > MAXC) ? 1 : 0;
            end else begin
                m_pend = 0;
            end
        end else if (xfer) begin
            m_pend = 0;
        end
        if (ovf_clear) begin
            m_ovfc  = 0;
            m_dropc = 0;
        end
        if (bx_strobe) begin
            bxm = bc0 ? 0 : ((bxm == BXM) ? 0 : bxm + 1);
            q.push_back('{due: cyc + L, bx: bxm});
        end
    endtask

    // Model advances on every edge; DUT outputs are compared 1 ns later.
    always @(posedge clk) begin
        if (!reset_n) mreset();
        else          mstep();
        cyc++;
        #1;
        chk("pack_start", 32'(pack_start), m_pend);
        chk("busy", 32'(busy), m_pend);
        chk("ovf_count", 32'(ovf_count), m_ovfc);
        chk("drop_count", 32'(drop_count), m_dropc);
        if (m_pend != 0) begin
            chk("pack_num", 32'(pack_num), m_num);
            chk("pack_bx", 32'(pack_bx), m_bx);
            chk("pack_ovf", 32'(pack_ovf), m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_cap(input bit b0, input int c);
        bx_strobe = 1'b1;
        bc0       = b0;
        cnt       = 8'd0;
        tick();
        bx_strobe = 1'b0;
        bc0       = 1'b0;
        repeat (L - 1) tick();
        cnt = 8'(c);
        tick();
        cnt = 8'd0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(pack_start), 0);
        chk({tag, "_num"},   32'(pack_num),   0);
        chk({tag, "_bx"},    32'(pack_bx),    0);
        chk({tag, "_ovf"},   32'(pack_ovf),   0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_ovfc"},  32'(ovf_count),  0);
        chk({tag, "_dropc"}, 32'(drop_count), 0);
    endtask

    int seq[$];
    int k;

    initial begin
        reset_n    = 1'b0;
        bx_strobe  = 1'b0;
        bc0        = 1'b0;
        cnt        = 8'd0;
        enable     = 1'b0;
        pack_ready = 1'b0;
        ovf_clear  = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // bc0 strobe, cnt=5 four cycles later, packer ready
        enable     = 1'b1;
        pack_ready = 1'b1;
        do_cap(1'b1, 5);
        chk("d1_start", 32'(pack_start), 1);
        chk("d1_num",   32'(pack_num),   5);
        chk("d1_bx",    32'(pack_bx),    0);
        chk("d1_ovf",   32'(pack_ovf),   0);
        tick();
        chk("d1_start_fall", 32'(pack_start), 0);

        // overflowing count
        do_cap(1'b0, 12);
        chk("d2_num",  32'(pack_num),  8);
        chk("d2_ovf",  32'(pack_ovf),  1);
        chk("d2_bx",   32'(pack_bx),   1);
        chk("d2_ovfc", 32'(ovf_count), 1);
        tick();

        // overwrite while packer stalled
        pack_ready = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            bx_strobe = (i == 0 || i == 4);
            cnt       = (i == 4) ? 8'd3 : ((i == 8) ? 8'd6 : 8'd0);
            tick();
            if (i == 4) chk("d3_num_first", 32'(pack_num), 3);
        end
        bx_strobe = 1'b0;
        cnt       = 8'd0;
        chk("d3_num",   32'(pack_num),   6);
        chk("d3_dropc", 32'(drop_count), 1);
        chk("d3_busy",  32'(busy),       1);
        pack_ready = 1'b1;
        tick();
        chk("d3_drain", 32'(busy), 0);

        // BX wrap: strobe every cycle from bc0 through 3560 and 640 beyond
        cnt = 8'd1;
        for (int i = 0; i < 3560 + 640; i++) begin
            bx_strobe = 1'b1;
            bc0       = (i == 0);
            tick();
            if (pack_start) seq.push_back(int'(pack_bx));
        end
        bx_strobe = 1'b0;
        bc0       = 1'b0;
        repeat (L + 1) tick();
        cnt = 8'd0;
        tick();
        k = -1;
        for (int i = 0; i + 2 < seq.size(); i++) begin
            if (k < 0 && seq[i] == 3563) k = i;
        end
        chk("wrap_found", 32'(k >= 0), 1);
        if (k >= 0) begin
            chk("wrap_to0", seq[k+1], 0);
            chk("wrap_to1", seq[k+2], 1);
        end

        // saturate ovf_count
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("sat_cleared", 32'(ovf_count), 0);
        cnt = 8'd12;
        for (int i = 0; i < 65535; i++) begin
            bx_strobe = 1'b1;
            tick();
        end
        bx_strobe = 1'b0;
        repeat (L) tick();
        cnt = 8'd0;
        chk("sat_full", 32'(ovf_count), 32'hFFFF);
        do_cap(1'b0, 12);
        chk("sat_hold", 32'(ovf_count), 32'hFFFF);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("clr_ovfc",  32'(ovf_count),  0);
        chk("clr_dropc", 32'(drop_count), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            bx_strobe  = ($urandom_range(0, 2) == 0);
            bc0        = ($urandom_range(0, 15) == 0);
            r          = $urandom_range(0, 9);
            cnt        = (r == 0) ? 8'd0 : ((r == 1) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(1, 8)));
            enable     = ($urandom_range(0, 7) != 0);
            pack_ready = ($urandom_range(0, 2) != 0);
            ovf_clear  = ($urandom_range(0, 63) == 0);
            tick();
        end
        bx_strobe  = 1'b0;
        bc0        = 1'b0;
        cnt        = 8'd0;
        enable     = 1'b1;
        ovf_clear  = 1'b1;
        pack_ready = 1'b1;
        repeat (L + 1) tick();
        ovf_clear = 1'b0;

        // asynchronous reset during a pending request
        pack_ready = 1'b0;
        do_cap(1'b0, 7);
        chk("ar_pend", 32'(pack_start), 1);
        chk("ar_drop_before", 32'(drop_count), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        tick();
        tick();
        reset_n    = 1'b1;
        pack_ready = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            tick();
            chk("ar_no_stale", 32'(pack_start), 0);
        end
        do_cap(1'b1, 2);
        chk("ar_fresh_start", 32'(pack_start), 1);
        chk("ar_fresh_num",   32'(pack_num),   2);
        chk("ar_fresh_bx",    32'(pack_bx),    0);
        chk("ar_fresh_drop",  32'(drop_count), 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
